// File: rtl/fpu_seq_if.sv
// fpu_seq_if: command and execution-unit handshake bundle for fpu_seq.
// Ports: cmd_* (valid/ready command channel) and eu_* (request/done unit
// channel). slave = sequencer side, master = host / execution-unit side.
interface fpu_seq_if #(
    parameter int W  = 32,
    parameter int AW = 5
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [2:0]    cmd_rm;
    logic [AW-1:0] cmd_src1;
    logic [AW-1:0] cmd_src2;
    logic [AW-1:0] cmd_dst;

    logic          eu_req;
    logic [2:0]    eu_op;
    logic [2:0]    eu_rm;
    logic [W-1:0]  eu_a;
    logic [W-1:0]  eu_b;
    logic          eu_done;
    logic [W-1:0]  eu_res;
    logic [4:0]    eu_flags;
    logic [2:0]    eu_cmp;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rm,
        input  cmd_src1, cmd_src2, cmd_dst,
        output cmd_ready,
        output eu_req, eu_op, eu_rm, eu_a, eu_b,
        input  eu_done, eu_res, eu_flags, eu_cmp
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rm,
        output cmd_src1, cmd_src2, cmd_dst,
        input  cmd_ready,
        input  eu_req, eu_op, eu_rm, eu_a, eu_b,
        output eu_done, eu_res, eu_flags, eu_cmp
    );
endinterface

// File: rtl/fpu_seq.sv
// fpu_seq: command sequencer for the single-precision FPU datapath.
// Owns the register file, fetches operands, issues one request per command
// to the execution units, waits for done, writes back and tracks flags.
// Ports: clk, rst (async, active-high); bus (fpu_seq_if.slave: cmd_* and
// eu_*); host_we/waddr/wdata, host_raddr/rdata (1-cycle read latency);
// busy, done, res_flags, sticky_flags, flags_clr, cmp_out, timeout_err.
// Optional: define FPU_SEQ_TIMEOUT_EN to abort after TIMEOUT cycles waiting.
module fpu_seq #(
    parameter int W       = 32,
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    fpu_seq_if.slave      bus,
    input  logic          host_we,
    input  logic [AW-1:0] host_waddr,
    input  logic [W-1:0]  host_wdata,
    input  logic [AW-1:0] host_raddr,
    output logic [W-1:0]  host_rdata,
    output logic          busy,
    output logic          done,
    output logic [4:0]    res_flags,
    output logic [4:0]    sticky_flags,
    input  logic          flags_clr,
    output logic [2:0]    cmp_out,
    output logic          timeout_err
);
    if (NREG < 2 || (1 << AW) != NREG || TIMEOUT < 1) begin : g_bad_cfg
        $error("fpu_seq: inconsistent NREG/AW/TIMEOUT");
    end

    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE, WAIT, WB
    } state_t;

    localparam logic [2:0] OP_SQRT = 3'd3;
    localparam logic [2:0] OP_CMP  = 3'd4;
    localparam logic [4:0] NV      = 5'b10000;

    state_t        state, state_nx;
    logic          up;
    logic [2:0]    op_q;
    logic [AW-1:0] src1_q, src2_q, dst_q;
    logic [W-1:0]  res_q;
    logic [4:0]    flg_q;
    logic [2:0]    cmp_q;
    logic          wr_q, cv_q;
    logic [W-1:0]  regs [NREG];

    logic accept, bad_op, in_eu, hit, expire;

    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign bad_op = op_q > OP_CMP;
    assign in_eu  = (state == ISSUE) || (state == WAIT);
    assign hit    = in_eu && bus.eu_done;

    // up holds cmd_ready low for the first cycle out of reset.
    assign bus.cmd_ready = up && (state == IDLE);
    assign bus.eu_req    = (state == ISSUE);
    assign busy          = (state != IDLE);
    assign done          = (state == WB);

`ifdef FPU_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;
    logic          to_q;

    // cnt is 0 in ISSUE and counts each cycle spent waiting.
    assign expire = in_eu && !bus.eu_done &&
                    (cnt == CW'(TIMEOUT - 1));
    assign timeout_err = done && to_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            to_q <= 1'b0;
        end else begin
            if (state == FETCH)
                cnt <= '0;
            else if (in_eu)
                cnt <= cnt + 1'b1;
            if (accept)
                to_q <= 1'b0;
            else if (expire)
                to_q <= 1'b1;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:        if (accept) state_nx = FETCH;
            FETCH:       state_nx = bad_op ? WB : ISSUE;
            ISSUE, WAIT: state_nx = (hit || expire) ? WB : WAIT;
            WB:          state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            up           <= 1'b0;
            op_q         <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            dst_q        <= '0;
            res_q        <= '0;
            flg_q        <= '0;
            cmp_q        <= '0;
            wr_q         <= 1'b0;
            cv_q         <= 1'b0;
            bus.eu_op    <= '0;
            bus.eu_rm    <= '0;
            bus.eu_a     <= '0;
            bus.eu_b     <= '0;
            res_flags    <= '0;
            sticky_flags <= '0;
            cmp_out      <= '0;
        end else begin
            state <= state_nx;
            up    <= 1'b1;
            if (accept) begin
                op_q      <= bus.cmd_op;
                src1_q    <= bus.cmd_src1;
                src2_q    <= bus.cmd_src2;
                dst_q     <= bus.cmd_dst;
                bus.eu_op <= bus.cmd_op;
                bus.eu_rm <= bus.cmd_rm;
                wr_q      <= 1'b0;
                cv_q      <= 1'b0;
            end
            // Operands are snapshotted here, so later host writes
            // cannot disturb the in-flight command.
            if (state == FETCH) begin
                bus.eu_a <= regs[src1_q];
                bus.eu_b <= (op_q == OP_SQRT) ? '0 : regs[src2_q];
                if (bad_op)
                    flg_q <= NV;
            end
            if (hit) begin
                res_q <= bus.eu_res;
                flg_q <= bus.eu_flags;
                cmp_q <= bus.eu_cmp;
                wr_q  <= (op_q != OP_CMP);
                cv_q  <= (op_q == OP_CMP);
            end else if (expire) begin
                flg_q <= NV;
            end
            if (state == WB) begin
                res_flags    <= flg_q;
                sticky_flags <= flags_clr ? flg_q : (sticky_flags | flg_q);
                if (cv_q)
                    cmp_out <= cmp_q;
            end else if (flags_clr) begin
                sticky_flags <= '0;
            end
        end
    end

    // Writeback is assigned after the host write so it wins on collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            host_rdata <= '0;
        end else begin
            host_rdata <= regs[host_raddr];
            if (host_we)
                regs[host_waddr] <= host_wdata;
            if (done && wr_q)
                regs[dst_q] <= res_q;
        end
    end
endmodule

// File: doc/fpu_seq.md
Name: fpu_seq

Overview:
- Parametrised command sequencer for the single-precision FPU datapath.
- Owns a multi-entry register file. Accepts opcode/src/dst commands over a valid/ready handshake. Fetches operands, issues one request to the execution units, waits for their done, writes back the result and accumulates IEEE exception flags.
- Replaces fixed done counters with a true request/done handshake, so each unit may have any latency.

Parameters:
- W, 32, datapath/register width in bits.
- NREG, 32, register file depth; must be a power of two, at least 2.
- AW, 5, register address width (log2 NREG).
- TIMEOUT, 64, cycles in WAIT before abort; used only with the optional feature.

Ports:
- clk  in  1  clock, all state rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- host_we  in  1  host register write strobe.
- host_waddr  in  AW  host write address.
- host_wdata  in  W  host write data.
- host_raddr  in  AW  host read address.
- host_rdata  out  W  registered read data, 1-cycle latency.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  sequencer idle, command accepted when valid&ready.
- cmd_op  in  3  opcode: 0 add, 1 mul, 2 div, 3 sqrt, 4 compare.
- cmd_rm  in  3  rounding mode, forwarded unchanged.
- cmd_src1, cmd_src2, cmd_dst  in  AW each  operand/result register addresses.
- eu_req  out  1  one-cycle request pulse to execution unit.
- eu_op  out  3  registered opcode; eu_rm  out  3  registered rounding mode.
- eu_a, eu_b  out  W each  registered operands.
- eu_done  in  1  unit result valid.
- eu_res  in  W  result.
- eu_flags  in  5  {nv,dz,of,uf,nx}.
- eu_cmp  in  3  {less,eq,great}.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- res_flags  out  5  flags of last completed command.
- sticky_flags  out  5  OR-accumulated flags.
- flags_clr  in  1  clear sticky_flags.
- cmp_out  out  3  last compare result.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; register file all zero.
  - All outputs 0, including cmd_ready.
  - cmd_ready rises the first cycle after rst deasserts.
  - Reset mid-operation drops the command; there is no writeback and no done.
- FSM IDLE -> FETCH -> ISSUE -> WAIT -> WB -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch op/rm/src1/src2/dst and go to FETCH.
- FETCH:
  - eu_a=reg[src1].
  - eu_b=reg[src2], or 0 for sqrt.
  - Invalid opcodes 5-7 skip directly to WB with res_flags=10000 and no writeback.
- ISSUE:
  - eu_req=1 for exactly one cycle.
  - eu_done is sampled here; if high, go to WB, else go to WAIT.
- WAIT: hold eu_* stable and stay until eu_done=1; eu_done outside ISSUE/WAIT is ignored.
- Capture: on eu_done, capture eu_res, eu_flags and eu_cmp.
- WB:
  - done=1 for one cycle.
  - res_flags updated.
  - sticky_flags |= flags.
  - For ops 0-3, write reg[dst]=eu_res. For op 4, there is no register write and cmp_out is updated.
  - Return to IDLE.
- Latency: accept at cycle 0, done at cycle 3 minimum (eu_done during ISSUE). Back-to-back throughput is one command per 4+ cycles.
- Host write:
  - Allowed in any state.
  - If host write and WB writeback target the same address in the same cycle, WB data wins.
  - Host writes to src registers after FETCH do not affect the in-flight op.
- Host read: host_rdata reflects register contents as of the previous edge, including same-cycle writes from the prior cycle.
- flags_clr with simultaneous WB: sticky_flags = new command flags only.
- cmd_op/src/dst changes while not ready are ignored.

Optional Feature:
- FPU_SEQ_TIMEOUT_EN defined:
  - A counter runs in ISSUE/WAIT.
  - After TIMEOUT cycles without eu_done, go to WB with no writeback, res_flags=10000 (sticky nv set), done=1 and timeout_err=1.
  - Counter clears on entry to ISSUE.
- Undefined: WAIT is unbounded and timeout_err is tied 0.

Test Plan:
- Reset, host write reg1=0x3F800000 and reg2=0x40000000, read back -> host_rdata matches 1 cycle after raddr; cmd_ready=0 during rst, 1 after.
- Add src1=1 src2=2 dst=3, eu_done 1 cycle after eu_req with eu_res=0x40400000 -> eu_req single pulse with eu_a=0x3F800000 and eu_b=0x40000000; done at cycle 4; reg3=0x40400000.
- Div with eu_flags=01000 and eu_done delayed 10 cycles, then flags_clr coincident with a later add done with flags=00001 -> res_flags=01000 then sticky=00001.
- Compare reg1 vs reg2, eu_cmp=100 -> cmp_out=100, reg[dst] unchanged, done pulse.
- Opcode 6 -> no eu_req, done at cycle 2, res_flags=10000; assert rst while in WAIT -> no writeback, busy=0, regs zero.
- With FPU_SEQ_TIMEOUT_EN and TIMEOUT=8, eu_done never asserted -> timeout_err and done 8 cycles after ISSUE entry, dst unchanged.
